// File: rtl/adder_mult_seq.sv
// adder_mult_seq: 32x32->64 shift-add multiplier time-sharing one external 32-bit adder.
// Optional early exit on exhausted multiplier bits: define MULT_EARLY_EXIT_EN.
module adder_mult_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  input  logic        add_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state;
  logic [31:0] hi, lo, mc;
  logic [4:0]  cnt;
  logic        skip;
  logic [63:0] nxt;
`ifdef MULT_EARLY_EXIT_EN
  // Remaining multiplier bits all zero: the rest of the work is a pure right shift.
  assign skip = state == RUN && (lo & (32'hFFFF_FFFF >> cnt)) == 32'd0;
  assign nxt  = skip ? {hi, lo} >> (6'd32 - {1'b0, cnt}) : {add_cout, add_sum, lo[31:1]};
`else
  assign skip = 1'b0;
  assign nxt  = {add_cout, add_sum, lo[31:1]};
`endif
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign product   = {hi, lo};
  assign add_cin   = 1'b0;
  // Adder inputs are quiet whenever no add is being performed.
  assign add_a = (state == RUN && !skip) ? hi : 32'd0;
  assign add_b = (state == RUN && !skip && lo[0]) ? mc : 32'd0;
  // Control FSM and datapath registers; the carry out becomes the new top bit each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hi    <= 32'd0;
      lo    <= 32'd0;
      mc    <= 32'd0;
      cnt   <= 5'd0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mc    <= mcand;
          hi    <= 32'd0;
          lo    <= mplier;
          cnt   <= 5'd0;
          state <= RUN;
        end
        RUN: begin
          {hi, lo} <= nxt;
          cnt      <= cnt + 5'd1;
          if (skip || cnt == 5'd31) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
